gpio_link_controller: RTL

- Sequences the 6-bit GPIO communication register pair so two battleship boards exchange 32-bit words over the narrow link.
- Serialises each TX word into 8 nibbles using a two-phase toggle handshake, and reassembles RX nibbles from the peer.
- Arbitrates the single shared write register between its TX and RX engines.
- Sits between the game processor (valid/ready word interface) and the communication memory (write / data_write / data_read).

---
 rtl/gpio_link_pkg.sv | 22 ++
 rtl/gpio_link_rx.sv | 47 ++++
 rtl/gpio_link_controller.sv | 131 +++++++++++++
 3 files changed

// File: rtl/gpio_link_pkg.sv
// Shared encodings and link-bit layout for the GPIO word link.
package gpio_link_pkg;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_SETUP = 2'd1,
    TX_REQ   = 2'd2,
    TX_WAIT  = 2'd3
  } tx_state_e;

  localparam int LINK_W           = 6;
  localparam int LINK_NIB_MSB     = 3;
  localparam int LINK_REQ         = 4;
  localparam int LINK_ACK         = 5;
  localparam int NIBBLES_PER_WORD = 8;

  // Select nibble idx of a word, LSB nibble first.
  function automatic logic [3:0] nibble_of(logic [31:0] w, logic [2:0] idx);
    return w[{idx, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/gpio_link_rx.sv
// RX engine: detects req toggles from the peer, assembles nibbles, toggles ack.
module gpio_link_rx
  import gpio_link_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [LINK_W-1:0] link_in,
  output logic              ack,
  output logic              ack_toggle,
  output logic              rx_valid,
  output logic [31:0]       rx_data
);

  logic        last_req_seen;
  logic [2:0]  rnib;
  logic [31:0] rx_shift;

  // A new nibble is present whenever the peer's req differs from the last one seen.
  assign ack_toggle = (link_in[LINK_REQ] != last_req_seen);

  // Capture nibble, acknowledge it, and publish the word after the eighth nibble.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_req_seen <= 1'b0;
      ack           <= 1'b0;
      rnib          <= 3'd0;
      rx_shift      <= 32'd0;
      rx_valid      <= 1'b0;
      rx_data       <= 32'd0;
    end else begin
      rx_valid <= 1'b0;
      if (ack_toggle) begin
        last_req_seen                 <= link_in[LINK_REQ];
        ack                           <= ~ack;
        rx_shift[{rnib, 2'b00} +: 4]  <= link_in[LINK_NIB_MSB:0];
        if (rnib == 3'(NIBBLES_PER_WORD - 1)) begin
          rx_data  <= {link_in[LINK_NIB_MSB:0], rx_shift[27:0]};
          rx_valid <= 1'b1;
          rnib     <= 3'd0;
        end else begin
          rnib <= rnib + 3'd1;
        end
      end
    end
  end

endmodule

// File: rtl/gpio_link_controller.sv
// Word-level link controller: TX nibble FSM, RX engine, shared write-register merge.
module gpio_link_controller
  import gpio_link_pkg::*;
#(
  parameter int SETUP_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int CNT_W          = 17
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        tx_valid,
  input  logic [31:0] tx_data,
  output logic        tx_ready,
  output logic        tx_done,
  output logic        tx_timeout,
  output logic        rx_valid,
  output logic [31:0] rx_data,
  output logic        mem_write,
  output logic [31:0] mem_data_write,
  input  logic [31:0] mem_data_read
);

  tx_state_e         state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [2:0]        nib, nib_nx;
  logic [31:0]       word, word_nx;
  logic [4:0]        tx_bits, tx_bits_nx;
  logic              done_nx, timeout_nx;
  logic [LINK_W-1:0] link_in;
  logic              ack, ack_toggle;
  logic              unused_hi;

  assign unused_hi = ^mem_data_read[31:LINK_W];

  // Extra sync stage on the registered GPIO input; every decision uses link_in.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) link_in <= '0;
    else        link_in <= mem_data_read[LINK_W-1:0];
  end

  gpio_link_rx u_rx (
    .clock      (clock),
    .reset      (reset),
    .link_in    (link_in),
    .ack        (ack),
    .ack_toggle (ack_toggle),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data)
  );

  // TX next-state: hold nibble, toggle req, wait for matching ack or timeout.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    nib_nx     = nib;
    word_nx    = word;
    tx_bits_nx = tx_bits;
    done_nx    = 1'b0;
    timeout_nx = 1'b0;
    case (state)
      TX_IDLE: begin
        if (tx_valid) begin
          word_nx  = tx_data;
          nib_nx   = 3'd0;
          cnt_nx   = '0;
          state_nx = TX_SETUP;
        end
      end
      TX_SETUP: begin
        tx_bits_nx[LINK_NIB_MSB:0] = nibble_of(word, nib);
        if (cnt == CNT_W'(SETUP_CYCLES - 1)) begin
          cnt_nx   = '0;
          state_nx = TX_REQ;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      TX_REQ: begin
        tx_bits_nx[LINK_REQ] = ~tx_bits[LINK_REQ];
        cnt_nx               = '0;
        state_nx             = TX_WAIT;
      end
      TX_WAIT: begin
        if (link_in[LINK_ACK] == tx_bits[LINK_REQ]) begin
          cnt_nx = '0;
          if (nib == 3'(NIBBLES_PER_WORD - 1)) begin
            done_nx  = 1'b1;
            state_nx = TX_IDLE;
          end else begin
            nib_nx   = nib + 3'd1;
            state_nx = TX_SETUP;
          end
        end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          // req stays toggled; both ends must reset to resync.
          timeout_nx = 1'b1;
          state_nx   = TX_IDLE;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: state_nx = TX_IDLE;
    endcase
  end

  // TX state plus merged write: one strobe covers any TX and/or RX bit change.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= TX_IDLE;
      cnt        <= '0;
      nib        <= 3'd0;
      word       <= 32'd0;
      tx_bits    <= 5'd0;
      tx_done    <= 1'b0;
      tx_timeout <= 1'b0;
      mem_write  <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      nib        <= nib_nx;
      word       <= word_nx;
      tx_bits    <= tx_bits_nx;
      tx_done    <= done_nx;
      tx_timeout <= timeout_nx;
      mem_write  <= (tx_bits_nx != tx_bits) || ack_toggle;
    end
  end

  assign tx_ready       = (state == TX_IDLE);
  assign mem_data_write = {26'd0, ack, tx_bits};

endmodule
